// File: rtl/parking_pkg.sv
// parking_pkg
// Types and constants shared by the parking-lot request front end and the
// elevator controller that consumes its task bundle.
//   PLATE_W     : license plate width (4 BCD digits)
//   FLOOR_W     : width of a floor number
//   MAX_FLOOR   : highest floor that can report a leakage
//   task_kind_t : kind of the task currently presented to the controller
//   floor_valid : true when a floor code names a real floor (1..MAX_FLOOR)
package parking_pkg;

  localparam int PLATE_W = 16;
  localparam int FLOOR_W = 3;
  localparam logic [FLOOR_W-1:0] MAX_FLOOR = 3'd7;

  typedef enum logic [1:0] {
    TASK_NONE,
    TASK_IN,
    TASK_OUT,
    TASK_LEAK
  } task_kind_t;

  // MAX_FLOOR is the all-ones code of FLOOR_W bits, so every nonzero code is a
  // real floor and only floor 0 has to be rejected.
  function automatic logic floor_valid(input logic [FLOOR_W-1:0] floor);
    return (floor != '0);
  endfunction

endpackage

// File: rtl/plate_fifo.sv
// plate_fifo
// Synchronous FIFO holding queued car requests ({is_out, plate}).
//   clock, reset : clock and synchronous active-high reset
//   push         : write push_data this edge (accepted when not full, or when
//                  a pop happens on the same edge)
//   pop          : drop the head entry this edge (ignored when empty)
//   push_data    : entry to write
//   pop_data     : current head entry (valid while empty is 0)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module plate_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign pop_data = mem[rd_ptr];

  // A pop on the same edge frees a slot, so a full FIFO still takes the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/parking_request_queue.sv
// parking_request_queue
// Front end for the parking lot's external request interface. Captures entry,
// exit and leakage pulses, queues car requests, and presents one task at a
// time to the elevator controller until it reports completion. A pending
// leakage always runs before queued car requests, but never interrupts the
// task already in progress.
//   clock, reset       : clock and synchronous active-high reset
//   license_plate      : plate attached to this cycle's in/out pulse
//   in_mode, out_mode  : one-cycle entry / exit request pulses
//   leakage            : one-cycle leakage event pulse
//   leakage_floor      : floor of the leakage event (1..7)
//   todo_done          : controller finished the active task
//   todo_exists        : active task valid
//   todo_in/out        : active task is an entry / exit
//   todo_leak_move     : active task is a leakage evacuation
//   todo_license_plate : plate of the active car task, 0 for leak tasks
//   todo_leak_floor    : floor of the active leak task, 0 otherwise
//   queue_count        : queued car requests, not counting the active task
//   dropped            : one-cycle pulse, car request lost to a full queue
//   illegal            : one-cycle pulse, malformed request rejected
module parking_request_queue #(
  parameter int DEPTH   = 8,
  parameter int PLATE_W = parking_pkg::PLATE_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PLATE_W-1:0]            license_plate,
  input  logic                          in_mode,
  input  logic                          out_mode,
  input  logic                          leakage,
  input  logic [parking_pkg::FLOOR_W-1:0] leakage_floor,
  input  logic                          todo_done,
  output logic                          todo_exists,
  output logic                          todo_in,
  output logic                          todo_out,
  output logic                          todo_leak_move,
  output logic [PLATE_W-1:0]            todo_license_plate,
  output logic [parking_pkg::FLOOR_W-1:0] todo_leak_floor,
  output logic [$clog2(DEPTH):0]        queue_count,
  output logic                          dropped,
  output logic                          illegal
);

  import parking_pkg::*;

  localparam int ENTRY_W = PLATE_W + 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               state;
  logic                 car_req;
  logic                 plate_valid;
  logic                 push_req;
  logic                 leak_req;
  logic                 illegal_next;
  logic                 dropped_next;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 leak_pending;
  logic [FLOOR_W-1:0]   leak_floor_q;
  task_kind_t           next_kind;

  // Request decoding. A car request needs exactly one of in/out plus a
  // nonzero plate; leakage is judged independently of the car request.
  assign car_req      = in_mode ^ out_mode;
  assign plate_valid  = (license_plate != '0);
  assign push_req     = car_req && plate_valid;
  assign leak_req     = leakage && floor_valid(leakage_floor);
  assign illegal_next = (in_mode && out_mode)
                     || ((in_mode || out_mode) && !plate_valid)
                     || (leakage && !floor_valid(leakage_floor));

  // The head is only taken when idle and no leak is waiting to go first.
  assign fifo_pop     = (state == IDLE) && !leak_pending && !fifo_empty;
  assign dropped_next = push_req && fifo_full && !fifo_pop;

  plate_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_plate_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .pop       (fifo_pop),
    .push_data ({out_mode, license_plate}),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

  // Chooses what an idle controller would load next: a waiting leak beats
  // anything queued.
  always_comb begin
    next_kind = TASK_NONE;
    if (leak_pending) begin
      next_kind = TASK_LEAK;
    end else if (!fifo_empty) begin
      next_kind = fifo_head[PLATE_W] ? TASK_OUT : TASK_IN;
    end
  end

  // Active-task FSM with registered task outputs, plus the leak-pending
  // register. A leak captured on the same edge that loads the previous leak
  // stays pending, so no event is lost; a newer leak overwrites the floor.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      todo_exists        <= 1'b0;
      todo_in            <= 1'b0;
      todo_out           <= 1'b0;
      todo_leak_move     <= 1'b0;
      todo_license_plate <= '0;
      todo_leak_floor    <= '0;
      leak_pending       <= 1'b0;
      leak_floor_q       <= '0;
      dropped            <= 1'b0;
      illegal            <= 1'b0;
    end else begin
      dropped <= dropped_next;
      illegal <= illegal_next;

      case (state)
        IDLE: begin
          if (next_kind != TASK_NONE) begin
            state              <= BUSY;
            todo_exists        <= 1'b1;
            todo_in            <= (next_kind == TASK_IN);
            todo_out           <= (next_kind == TASK_OUT);
            todo_leak_move     <= (next_kind == TASK_LEAK);
            todo_license_plate <= (next_kind == TASK_LEAK) ? '0 : fifo_head[PLATE_W-1:0];
            todo_leak_floor    <= (next_kind == TASK_LEAK) ? leak_floor_q : '0;
          end
        end
        BUSY: begin
          if (todo_done) begin
            state              <= IDLE;
            todo_exists        <= 1'b0;
            todo_in            <= 1'b0;
            todo_out           <= 1'b0;
            todo_leak_move     <= 1'b0;
            todo_license_plate <= '0;
            todo_leak_floor    <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if ((state == IDLE) && leak_pending) leak_pending <= 1'b0;
      if (leak_req) begin
        leak_pending <= 1'b1;
        leak_floor_q <= leakage_floor;
      end
    end
  end

endmodule

// File: tb/tb_parking_request_queue.sv
// tb_parking_request_queue
// Directed bench for parking_request_queue. Car requests and leak events are
// recorded in a scoreboard as they are driven; whenever a task is due to be
// active, the expected task is taken from the scoreboard (pending leak first,
// then the oldest queued car) and compared with the todo_* bundle.
module tb_parking_request_queue;

  import parking_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic               is_out;
    logic [PLATE_W-1:0] plate;
  } car_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [PLATE_W-1:0] license_plate = '0;
  logic               in_mode = 1'b0;
  logic               out_mode = 1'b0;
  logic               leakage = 1'b0;
  logic [FLOOR_W-1:0] leakage_floor = '0;
  logic               todo_done = 1'b0;
  logic               todo_exists;
  logic               todo_in;
  logic               todo_out;
  logic               todo_leak_move;
  logic [PLATE_W-1:0] todo_license_plate;
  logic [FLOOR_W-1:0] todo_leak_floor;
  logic [CNT_W-1:0]   queue_count;
  logic               dropped;
  logic               illegal;

  car_t               car_q[$];
  logic               m_leak_valid = 1'b0;
  logic [FLOOR_W-1:0] m_leak_floor = '0;
  int                 checks = 0;
  int                 errors = 0;

  parking_request_queue #(
    .DEPTH   (DEPTH),
    .PLATE_W (PLATE_W)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .license_plate      (license_plate),
    .in_mode            (in_mode),
    .out_mode           (out_mode),
    .leakage            (leakage),
    .leakage_floor      (leakage_floor),
    .todo_done          (todo_done),
    .todo_exists        (todo_exists),
    .todo_in            (todo_in),
    .todo_out           (todo_out),
    .todo_leak_move     (todo_leak_move),
    .todo_license_plate (todo_license_plate),
    .todo_leak_floor    (todo_leak_floor),
    .queue_count        (queue_count),
    .dropped            (dropped),
    .illegal            (illegal)
  );

  always #5 clock = ~clock;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of request inputs, record it in the scoreboard, and check
  // the illegal/dropped pulses that follow the sampling edge.
  task automatic apply_stimulus(input string tag, input logic im, input logic om,
                                input logic [PLATE_W-1:0] plate, input logic lk,
                                input logic [FLOOR_W-1:0] fl, input logic exp_drop);
    car_t c;
    logic exp_ill;
    in_mode       = im;
    out_mode      = om;
    license_plate = plate;
    leakage       = lk;
    leakage_floor = fl;
    if ((im ^ om) && (plate != '0) && !exp_drop) begin
      c.is_out = om;
      c.plate  = plate;
      car_q.push_back(c);
    end
    if (lk && (fl != '0)) begin
      m_leak_valid = 1'b1;
      m_leak_floor = fl;
    end
    exp_ill = (im && om) || ((im || om) && (plate == '0)) || (lk && (fl == '0));
    tick();
    in_mode       = 1'b0;
    out_mode      = 1'b0;
    license_plate = '0;
    leakage       = 1'b0;
    leakage_floor = '0;
    check_output({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    check_output({tag, "_dropped"}, 32'(dropped), 32'(exp_drop));
  endtask

  // Compare the active task with the next task the scoreboard predicts.
  task automatic check_active(input string tag);
    car_t               c;
    logic               e_in = 1'b0;
    logic               e_out = 1'b0;
    logic               e_leak = 1'b0;
    logic [PLATE_W-1:0] e_plate = '0;
    logic [FLOOR_W-1:0] e_floor = '0;
    if (m_leak_valid) begin
      e_leak       = 1'b1;
      e_floor      = m_leak_floor;
      m_leak_valid = 1'b0;
    end else if (car_q.size() > 0) begin
      c       = car_q.pop_front();
      e_in    = !c.is_out;
      e_out   = c.is_out;
      e_plate = c.plate;
    end
    check_output({tag, "_exists"}, 32'(todo_exists), 32'(e_in | e_out | e_leak));
    check_output({tag, "_in"},     32'(todo_in), 32'(e_in));
    check_output({tag, "_out"},    32'(todo_out), 32'(e_out));
    check_output({tag, "_leak"},   32'(todo_leak_move), 32'(e_leak));
    check_output({tag, "_plate"},  32'(todo_license_plate), 32'(e_plate));
    check_output({tag, "_floor"},  32'(todo_leak_floor), 32'(e_floor));
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_exists"}, 32'(todo_exists), 32'd0);
    check_output({tag, "_in"},     32'(todo_in), 32'd0);
    check_output({tag, "_out"},    32'(todo_out), 32'd0);
    check_output({tag, "_leak"},   32'(todo_leak_move), 32'd0);
    check_output({tag, "_plate"},  32'(todo_license_plate), 32'd0);
    check_output({tag, "_floor"},  32'(todo_leak_floor), 32'd0);
    check_output({tag, "_dropped"}, 32'(dropped), 32'd0);
    check_output({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  // Pulse todo_done for one edge; the active task must clear on that edge.
  task automatic finish_task(input string tag);
    todo_done = 1'b1;
    tick();
    todo_done = 1'b0;
    check_output({tag, "_cleared"}, 32'(todo_exists), 32'd0);
  endtask

  initial begin
    $display("[TB] parking_request_queue bench start");

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check_idle("reset");
    check_output("reset_count", 32'(queue_count), 32'd0);
    reset = 1'b0;

    // Single entry request: pushed at N, active after N+1
    apply_stimulus("entry", 1'b1, 1'b0, 16'h9423, 1'b0, 3'd0, 1'b0);
    check_output("entry_n_exists", 32'(todo_exists), 32'd0);
    check_output("entry_n_count", 32'(queue_count), 32'd1);
    tick();
    check_active("entry");
    check_output("entry_count", 32'(queue_count), 32'd0);
    finish_task("entry_done");
    check_output("entry_done_count", 32'(queue_count), 32'd0);
    tick();
    check_output("entry_stays_idle", 32'(todo_exists), 32'd0);

    // Exit request and leakage in the same cycle: leak runs first
    apply_stimulus("simul", 1'b0, 1'b1, 16'h8754, 1'b1, 3'd2, 1'b0);
    tick();
    check_active("simul_leak");
    finish_task("simul_leak_done");
    tick();
    check_active("simul_out");
    finish_task("simul_out_done");
    tick();

    // Leak arriving while busy jumps ahead of a queued car; latest floor wins
    apply_stimulus("prio_a", 1'b1, 1'b0, 16'h5755, 1'b0, 3'd0, 1'b0);
    tick();
    check_active("prio_first");
    apply_stimulus("prio_b", 1'b1, 1'b0, 16'h8750, 1'b0, 3'd0, 1'b0);
    check_output("prio_queued", 32'(queue_count), 32'd1);
    apply_stimulus("prio_leak6", 1'b0, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0);
    apply_stimulus("prio_leak3", 1'b0, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0);
    tick();
    check_output("prio_held_plate", 32'(todo_license_plate), 32'h5755);
    finish_task("prio_first_done");
    tick();
    check_active("prio_leak");
    finish_task("prio_leak_done");
    tick();
    check_active("prio_car");
    finish_task("prio_car_done");
    tick();

    // Overflow: first request goes active, 8 queue, the 10th is dropped
    for (int i = 0; i < 10; i++) begin
      apply_stimulus("ovf", 1'b1, 1'b0, PLATE_W'(16'h1000 + i), 1'b0, 3'd0, (i == 9));
    end
    check_output("ovf_full_count", 32'(queue_count), 32'd8);
    check_active("ovf_active");
    finish_task("ovf_active_done");
    // Push on the same edge as the pop from a full queue is accepted
    apply_stimulus("ovf_pushpop", 1'b1, 1'b0, 16'h7777, 1'b0, 3'd0, 1'b0);
    check_active("ovf_next");
    check_output("ovf_pushpop_count", 32'(queue_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      finish_task("ovf_drain_done");
      tick();
      check_active("ovf_drain");
    end
    finish_task("ovf_last_done");
    tick();
    check_output("ovf_empty_count", 32'(queue_count), 32'd0);
    check_output("ovf_empty_exists", 32'(todo_exists), 32'd0);

    // Malformed requests: illegal pulse, nothing queued or loaded
    apply_stimulus("ill_both", 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0);
    check_output("ill_both_count", 32'(queue_count), 32'd0);
    apply_stimulus("ill_zero", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
    check_output("ill_zero_count", 32'(queue_count), 32'd0);
    apply_stimulus("ill_floor", 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0);
    tick();
    check_output("ill_pulse_end", 32'(illegal), 32'd0);
    check_output("ill_no_task", 32'(todo_exists), 32'd0);
    check_output("ill_no_count", 32'(queue_count), 32'd0);

    // Reset mid-operation discards active, queued and pending work
    apply_stimulus("rst_a", 1'b1, 1'b0, 16'h2001, 1'b0, 3'd0, 1'b0);
    tick();
    check_active("rst_active");
    apply_stimulus("rst_b", 1'b1, 1'b0, 16'h2002, 1'b0, 3'd0, 1'b0);
    apply_stimulus("rst_c", 1'b0, 1'b1, 16'h2003, 1'b0, 3'd0, 1'b0);
    apply_stimulus("rst_d", 1'b1, 1'b0, 16'h2004, 1'b0, 3'd0, 1'b0);
    apply_stimulus("rst_leak", 1'b0, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0);
    check_output("rst_pre_count", 32'(queue_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    car_q.delete();
    m_leak_valid = 1'b0;
    check_idle("rst_mid");
    check_output("rst_mid_count", 32'(queue_count), 32'd0);
    todo_done = 1'b1;
    tick();
    todo_done = 1'b0;
    check_output("rst_done_ignored", 32'(todo_exists), 32'd0);
    tick();
    check_output("rst_still_idle", 32'(todo_exists), 32'd0);
    check_output("rst_still_empty", 32'(queue_count), 32'd0);
    apply_stimulus("post_rst", 1'b1, 1'b0, 16'h3141, 1'b0, 3'd0, 1'b0);
    tick();
    check_active("post_rst");
    finish_task("post_rst_done");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_request_queue.md
# parking_request_queue

- Front-end receiver for the parking lot's external request interface.
- Samples single-cycle request pulses (`in_mode`, `out_mode`, `leakage` + `leakage_floor`) with the associated `license_plate`, and queues car requests in a FIFO.
- Gives leakage events priority.
- Presents one active task at a time to the elevator controller as the `todo_*` bundle, held until the controller acknowledges completion with `todo_done`.
- Sits between the top-level inputs and the elevator/slot-allocation FSM inside `parking_lot_top`.

## Interface
- `DEPTH`, 8: car-request FIFO entries; power of two, ≥2.
- `PLATE_W`, 16: license plate width (4 BCD digits).
- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `license_plate` in PLATE_W: plate for the in/out request of this cycle.
- `in_mode` in 1: one-cycle pulse, car entry request.
- `out_mode` in 1: one-cycle pulse, car exit request.
- `leakage` in 1: one-cycle pulse, leakage event.
- `leakage_floor` in 3: floor of the leakage event, 1–7.
- `todo_done` in 1: controller finished the active task; one-cycle pulse.
- `todo_exists` out 1: active task valid.
- `todo_in` out 1: active task is an entry.
- `todo_out` out 1: active task is an exit.
- `todo_leak_move` out 1: active task is a leakage evacuation.
- `todo_license_plate` out PLATE_W: plate of the active in/out task; 0 for leak tasks.
- `todo_leak_floor` out 3: floor of the active leak task; 0 otherwise.
- `queue_count` out $clog2(DEPTH)+1: FIFO occupancy, excluding the active task.
- `dropped` out 1: one-cycle pulse, request discarded (FIFO full).
- `illegal` out 1: one-cycle pulse, malformed request rejected.

## Operation
- Three parts: car FIFO (entry = {is_out, plate}), leak-pending register (valid, floor), active-task register.
- Capture: each posedge with `reset`=0:
  - `in_mode` XOR `out_mode` with plate ≠ 0 → push {out_mode, plate}.
  - `in_mode` AND `out_mode` → no push; `illegal`=1.
  - in/out with plate = 0 → no push; `illegal`=1.
  - `leakage` with floor 1–7 → leak_pending=1, leak_floor=floor. A later leakage while pending overwrites the floor (latest wins).
  - `leakage` with floor 0 → `illegal`=1.
  - Leakage and in/out in the same cycle are both captured independently.
- FIFO full:
  - Push when full and no pop this cycle → `dropped`=1, entry lost, FIFO unchanged.
  - Push and pop in the same cycle when full → push accepted.
- Active-task state machine:
  - IDLE: if leak_pending → load leak task, clear leak_pending, go BUSY. Else if FIFO non-empty → pop head into active, go BUSY. Else stay IDLE.
  - BUSY: outputs held constant. On `todo_done` → IDLE; active cleared the same edge.
  - The next task loads on the following edge, so there is always ≥1 idle cycle between tasks.
  - No preemption: a leak arriving during BUSY waits for `todo_done`, then goes ahead of all queued car requests.
- `todo_done` in IDLE is ignored (no error).
- Outputs are registered. Exactly one of `todo_in` / `todo_out` / `todo_leak_move` is 1 iff `todo_exists`=1.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter, 0..DEPTH.

## Timing
- Reset values:
  - All outputs 0; `queue_count`=0.
  - FIFO empty, leak_pending=0, state IDLE.
- Reset mid-operation discards the active task, the pending leak, and all queued entries. No `dropped` pulse.
- Latency, request to `todo_exists`, when empty and IDLE:
  - Request sampled at edge N; FIFO push at N.
  - Active loaded at N+1; `todo_exists`=1 after N+1.
- Latency for a leak: leak_pending set at N, active loaded at N+1, same 2-edge path.
- `todo_done` sampled at edge M → `todo_exists`=0 after M. The next task is visible after M+1.
- `dropped` / `illegal` assert in the cycle after the offending edge, for exactly one cycle.

## Structure
- Shared package `parking_pkg`:
  - `PLATE_W`.
  - Task-kind enum {TASK_NONE, TASK_IN, TASK_OUT, TASK_LEAK}.
  - Floor width constant (3).
  - Max floor constant (7).
- One sub-module: `plate_fifo` (DEPTH × (1+PLATE_W), synchronous push/pop, full/empty/count).
- Capture logic and active-task FSM stay in `parking_request_queue`.

## Test plan
- Entry: `in_mode`=1, plate 9423 for one cycle → 2 edges later `todo_exists`=1, `todo_in`=1, plate 9423. `todo_done` → clears next edge; `queue_count`=0.
- Simultaneous: `out_mode`=1, plate 8754, `leakage`=1, floor 2, same cycle, IDLE → first task `todo_leak_move`=1, floor 2. After `todo_done`, the next task is `todo_out`, plate 8754.
- Priority while BUSY: active in 5755; queue in 8750; then leakage floor 3 → after `todo_done`, the leak (floor 3) runs before 8750.
- Overflow: `todo_done` held 0, DEPTH=8, 10 distinct in-requests → first is active, next 8 queued, 10th gives `dropped`=1, `queue_count`=8.
- Malformed requests → `illegal`=1, no push for each of:
  - `in_mode`=`out_mode`=1, plate 1234.
  - `in_mode`=1, plate 0000.
  - `leakage`=1, floor 0.
- Reset mid-op: 3 queued + active + pending leak, assert `reset` one cycle → all outputs 0. `todo_done` afterward has no effect.
